// File: rtl/mem_access_ctrl.sv
// Memory-side sequencer for the MDR stage: latches MAR/MDRout, strobes the RAM for
// WAIT_STATES+1 cycles, and hands read words to the MDR with a one-cycle load.
module mem_access_ctrl #(
    parameter int unsigned ADDR_W      = 9,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start_read,
    input  logic              start_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic              conflict,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_re,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] Mdatain,
    output logic              mdr_read,
    output logic              mdr_enable
);

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_LOAD,
        WR_ACTIVE,
        WR_DONE
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES);

    state_t            state, state_n;
    logic [3:0]        cnt, cnt_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [DATA_W-1:0] wdata_q, wdata_n;
    logic [DATA_W-1:0] mdat_q, mdat_n;
    logic              conflict_q, conflict_n;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state      <= IDLE;
            cnt        <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            mdat_q     <= '0;
            conflict_q <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            addr_q     <= addr_n;
            wdata_q    <= wdata_n;
            mdat_q     <= mdat_n;
            conflict_q <= conflict_n;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        addr_n     = addr_q;
        wdata_n    = wdata_q;
        mdat_n     = mdat_q;
        conflict_n = 1'b0;
        case (state)
            IDLE: begin
                // Read wins a tie; the conflict flag is registered, so it pulses
                // in the first cycle after the accept edge.
                if (start_read) begin
                    state_n    = RD_WAIT;
                    addr_n     = addr;
                    cnt_n      = CNT_INIT;
                    conflict_n = start_write;
                end else if (start_write) begin
                    state_n = WR_ACTIVE;
                    addr_n  = addr;
                    wdata_n = wdata;
                    cnt_n   = CNT_INIT;
                end
            end
            RD_WAIT: begin
                if (cnt == '0) begin
                    mdat_n  = mem_rdata;
                    state_n = RD_LOAD;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            RD_LOAD: state_n = IDLE;
            WR_ACTIVE: begin
                if (cnt == '0) begin
                    state_n = WR_DONE;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            WR_DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign busy       = (state != IDLE);
    assign done       = (state == RD_LOAD) || (state == WR_DONE);
    assign conflict   = conflict_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign mem_re     = (state == RD_WAIT);
    assign mem_we     = (state == WR_ACTIVE);
    assign Mdatain    = mdat_q;
    assign mdr_read   = (state == RD_LOAD);
    assign mdr_enable = (state == RD_LOAD);

endmodule
